// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
//
// Shares one synchronous SRAM port between the fetch stage (instruction
// requester) and the memory-access stage (data requester). At most one access
// is granted per cycle. The grant is combinational, and the read data returns
// one cycle later to whichever requester owns the in-flight access.
//
// Data accesses normally win. A starvation counter tracks how many times in a
// row data has been granted while fetch was waiting. When it reaches
// STARVE_LIMIT, the next contested cycle goes to fetch.
//
// Ports:
//   clk, reset                 clock and synchronous active-high reset
//   inst_req/inst_addr         fetch read request
//   inst_addr_ok               fetch request granted this cycle
//   inst_data_ok/inst_rdata    fetch read response (one cycle after grant)
//   data_req/data_wr/...       memory-stage request (read or byte-masked write)
//   data_addr_ok               data request granted this cycle
//   data_data_ok/data_rdata    data response (one cycle after grant)
//   sram_en/we/addr/wdata      SRAM command, driven in the grant cycle
//   sram_rdata                 SRAM read data, valid the cycle after sram_en
module sram_port_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                reset,
  // fetch requester
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic                inst_addr_ok,
  output logic                inst_data_ok,
  output logic [DATA_W-1:0]   inst_rdata,
  // memory-stage requester
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [DATA_W/8-1:0] data_wstrb,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_addr_ok,
  output logic                data_data_ok,
  output logic [DATA_W-1:0]   data_rdata,
  // SRAM port
  output logic                sram_en,
  output logic [DATA_W/8-1:0] sram_we,
  output logic [ADDR_W-1:0]   sram_addr,
  output logic [DATA_W-1:0]   sram_wdata,
  input  logic [DATA_W-1:0]   sram_rdata
);

  localparam int unsigned StrbW = DATA_W / 8;
  localparam int unsigned CntW  = $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(STARVE_LIMIT);

  // Owner of the access currently in flight on the SRAM.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StInst = 2'd1,
    StData = 2'd2
  } owner_e;

  owner_e          owner_q;
  logic [CntW-1:0] starve_q, starve_d;
  logic            grant_inst, grant_data, fetch_forced;

  // ---------------------------------------------------------------------------
  // Grant decision
  // ---------------------------------------------------------------------------
  // Fetch is forced through only when both requesters compete and fetch has
  // already lost STARVE_LIMIT times in a row.
  assign fetch_forced = inst_req && (starve_q == CntMax);

  always_comb begin
    grant_inst = 1'b0;
    grant_data = 1'b0;
    if (!reset) begin
      if (data_req && !fetch_forced) begin
        grant_data = 1'b1;
      end else if (inst_req) begin
        grant_inst = 1'b1;
      end
    end
  end

  assign inst_addr_ok = grant_inst;
  assign data_addr_ok = grant_data;

  // ---------------------------------------------------------------------------
  // SRAM command
  // ---------------------------------------------------------------------------
  always_comb begin
    sram_en    = 1'b0;
    sram_we    = '0;
    sram_addr  = '0;
    sram_wdata = '0;
    if (grant_data) begin
      sram_en    = 1'b1;
      sram_addr  = data_addr;
      sram_wdata = data_wdata;
      sram_we    = data_wr ? data_wstrb : {StrbW{1'b0}};
    end else if (grant_inst) begin
      sram_en    = 1'b1;
      sram_addr  = inst_addr;
      sram_wdata = data_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Starvation counter
  // ---------------------------------------------------------------------------
  // The counter only counts losses that fetch actually suffered. If fetch
  // stops asking, the history is irrelevant and the counter is cleared.
  always_comb begin
    starve_d = starve_q;
    if (grant_inst || !inst_req) begin
      starve_d = '0;
    end else if (grant_data && (starve_q != CntMax)) begin
      starve_d = starve_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Owner FSM: remembers who was granted so the response can be routed back
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q <= StIdle;
    end else begin
      unique case (1'b1)
        grant_data: owner_q <= StData;
        grant_inst: owner_q <= StInst;
        default:    owner_q <= StIdle;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Response routing
  // ---------------------------------------------------------------------------
  // The responses are gated by reset. An access granted in the cycle just
  // before reset is dropped rather than delivered while reset is high.
  always_comb begin
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    inst_rdata   = '0;
    data_rdata   = '0;
    if (!reset) begin
      unique case (owner_q)
        StInst: begin
          inst_data_ok = 1'b1;
          inst_rdata   = sram_rdata;
        end
        StData: begin
          data_data_ok = 1'b1;
          data_rdata   = sram_rdata;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
module tb_sram_port_arbiter;

  localparam int STARVE_LIMIT = 4;

  logic        clk, reset;
  logic        inst_req, inst_addr_ok, inst_data_ok;
  logic [31:0] inst_addr, inst_rdata;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [3:0]  data_wstrb, sram_we;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        sram_en;
  logic [31:0] sram_addr, sram_wdata, sram_rdata;

  sram_port_arbiter #(
    .ADDR_W(32),
    .DATA_W(32),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // SRAM emulation: it follows whatever the DUT drives. Idle cycles return junk.
  // ---------------------------------------------------------------------------
  logic [31:0] sram_mem [logic [31:0]];

  function automatic logic [31:0] sram_get(input logic [31:0] a);
    if (sram_mem.exists(a)) return sram_mem[a];
    return a ^ 32'ha5a5_0000;
  endfunction

  always @(posedge clk) begin
    if (sram_en) begin
      logic [31:0] w;
      w = sram_get(sram_addr);
      sram_rdata <= w;
      if (sram_we != 4'b0) begin
        for (int b = 0; b < 4; b++)
          if (sram_we[b]) w[8*b +: 8] = sram_wdata[8*b +: 8];
        sram_mem[sram_addr] = w;
      end
    end else begin
      sram_rdata <= $urandom;
    end
  end

  // ---------------------------------------------------------------------------
  // Reference model: grant rule, owner of the pending response, and a
  // reference memory.
  // ---------------------------------------------------------------------------
  logic [31:0] ref_mem [logic [31:0]];
  int          m_owner  = 0;   // 0 none, 1 inst, 2 data
  bit          m_wr     = 0;
  logic [31:0] m_rdata  = '0;
  int          m_starve = 0;
  bit          g_inst, g_data;
  logic        s_iaok, s_daok, s_idok, s_ddok;
  logic [31:0] s_irdata, s_drdata;

  function automatic logic [31:0] ref_get(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return a ^ 32'ha5a5_0000;
  endfunction

  // One clock cycle: drive the inputs, then check all outputs at negedge
  // against the model, then advance the model.
  task automatic step(input bit rst, input bit ireq, input logic [31:0] ia,
                      input bit dreq, input bit dwr, input logic [3:0] st,
                      input logic [31:0] da, input logic [31:0] dw);
    bit gi, gd, e_idok, e_ddok;
    logic [31:0] e_addr;
    reset = rst; inst_req = ireq; inst_addr = ia;
    data_req = dreq; data_wr = dwr; data_wstrb = st; data_addr = da; data_wdata = dw;
    @(negedge clk);
    gi = 0; gd = 0;
    if (!rst) begin
      if (ireq && dreq) begin
        if (m_starve >= STARVE_LIMIT) gi = 1; else gd = 1;
      end else begin
        gi = ireq; gd = dreq;
      end
    end
    e_idok = !rst && m_owner == 1;
    e_ddok = !rst && m_owner == 2;
    e_addr = gi ? ia : (gd ? da : 32'h0);
    s_iaok = inst_addr_ok; s_daok = data_addr_ok;
    s_idok = inst_data_ok; s_ddok = data_data_ok;
    s_irdata = inst_rdata; s_drdata = data_rdata;
    chk("inst_addr_ok", {31'b0, inst_addr_ok}, {31'b0, gi});
    chk("data_addr_ok", {31'b0, data_addr_ok}, {31'b0, gd});
    chk("sram_en", {31'b0, sram_en}, {31'b0, gi | gd});
    chk("sram_addr", sram_addr, e_addr);
    chk("sram_we", {28'b0, sram_we}, {28'b0, (gd && dwr) ? st : 4'b0});
    chk("sram_wdata", sram_wdata, (gi || gd) ? dw : 32'h0);
    chk("inst_data_ok", {31'b0, inst_data_ok}, {31'b0, e_idok});
    chk("data_data_ok", {31'b0, data_data_ok}, {31'b0, e_ddok});
    chk("inst_rdata", inst_rdata, e_idok ? m_rdata : 32'h0);
    if (!(e_ddok && m_wr)) chk("data_rdata", data_rdata, e_ddok ? m_rdata : 32'h0);
    // advance model
    m_owner = gd ? 2 : (gi ? 1 : 0);
    m_wr = gd && dwr;
    if (gi) m_rdata = ref_get(ia);
    if (gd) begin
      logic [31:0] w;
      w = ref_get(da);
      m_rdata = w;
      if (dwr && st != 4'b0) begin
        for (int b = 0; b < 4; b++) if (st[b]) w[8*b +: 8] = dw[8*b +: 8];
        ref_mem[da] = w;
      end
    end
    if (rst || gi || !ireq) m_starve = 0;
    else if (gd && m_starve < STARVE_LIMIT) m_starve++;
    g_inst = gi; g_data = gd;
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Directed vectors
  // ---------------------------------------------------------------------------
  typedef struct packed {
    bit          rst, ireq;
    logic [31:0] ia;
    bit          dreq, dwr;
    logic [3:0]  st;
    logic [31:0] da, dw;
    bit          e_iaok, e_daok, e_idok, e_ddok, chk_rd;
    logic [31:0] e_rdata;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  function automatic vec_t mk(bit rst, bit ireq, logic [31:0] ia, bit dreq, bit dwr,
                              logic [3:0] st, logic [31:0] da, logic [31:0] dw,
                              bit iaok, bit daok, bit idok, bit ddok, bit cr,
                              logic [31:0] rd);
    vec_t v;
    v.rst = rst; v.ireq = ireq; v.ia = ia; v.dreq = dreq; v.dwr = dwr; v.st = st;
    v.da = da; v.dw = dw; v.e_iaok = iaok; v.e_daok = daok; v.e_idok = idok;
    v.e_ddok = ddok; v.chk_rd = cr; v.e_rdata = rd;
    return v;
  endfunction

  bit          p_i, p_d, p_dwr;
  logic [31:0] p_ia, p_da, p_dw;
  logic [3:0]  p_st;

  initial begin
    reset = 1'b1; inst_req = 0; inst_addr = 0; data_req = 0; data_wr = 0;
    data_wstrb = 0; data_addr = 0; data_wdata = 0;
    sram_mem[32'h1c00_0000] = 32'h0280_0000;  ref_mem[32'h1c00_0000] = 32'h0280_0000;
    sram_mem[32'h40]        = 32'h1122_3344;  ref_mem[32'h40]        = 32'h1122_3344;

    //               rst i  ia            d  wr st     da      dw            iaok daok idok ddok cr rdata
    vecs[0]  = mk(1, 1, 32'h200,      1, 0, 4'h0, 32'h100, 32'h0,        0, 0, 0, 0, 0, 32'h0);
    vecs[1]  = mk(1, 1, 32'h200,      1, 0, 4'h0, 32'h100, 32'h0,        0, 0, 0, 0, 0, 32'h0);
    vecs[2]  = mk(1, 1, 32'h200,      1, 0, 4'h0, 32'h100, 32'h0,        0, 0, 0, 0, 0, 32'h0);
    vecs[3]  = mk(0, 1, 32'h1c000000, 0, 0, 4'h0, 32'h0,   32'h0,        1, 0, 0, 0, 0, 32'h0);
    vecs[4]  = mk(0, 0, 32'h0,        0, 0, 4'h0, 32'h0,   32'h0,        0, 0, 1, 0, 1, 32'h02800000);
    vecs[5]  = mk(0, 1, 32'h200,      1, 0, 4'h0, 32'h100, 32'h0,        0, 1, 0, 0, 0, 32'h0);
    vecs[6]  = mk(0, 1, 32'h200,      0, 0, 4'h0, 32'h0,   32'h0,        1, 0, 0, 1, 1, 32'ha5a50100);
    vecs[7]  = mk(0, 0, 32'h0,        1, 1, 4'h3, 32'h40,  32'hdeadbeef, 0, 1, 1, 0, 1, 32'ha5a50200);
    vecs[8]  = mk(0, 0, 32'h0,        1, 0, 4'h0, 32'h40,  32'h0,        0, 1, 0, 1, 0, 32'h0);
    vecs[9]  = mk(0, 0, 32'h0,        0, 0, 4'h0, 32'h0,   32'h0,        0, 0, 0, 1, 1, 32'h1122beef);
    vecs[10] = mk(0, 1, 32'h300,      0, 0, 4'h0, 32'h0,   32'h0,        1, 0, 0, 0, 0, 32'h0);
    vecs[11] = mk(1, 1, 32'h304,      0, 0, 4'h0, 32'h0,   32'h0,        0, 0, 0, 0, 0, 32'h0);
    vecs[12] = mk(0, 1, 32'h308,      0, 0, 4'h0, 32'h0,   32'h0,        1, 0, 0, 0, 0, 32'h0);
    vecs[13] = mk(0, 0, 32'h0,        0, 0, 4'h0, 32'h0,   32'h0,        0, 0, 1, 0, 1, 32'ha5a50308);
    vecs[14] = mk(0, 0, 32'h0,        1, 1, 4'h0, 32'h40,  32'hffffffff, 0, 1, 0, 0, 0, 32'h0);
    vecs[15] = mk(0, 0, 32'h0,        1, 0, 4'h0, 32'h40,  32'h0,        0, 1, 0, 1, 0, 32'h0);
    vecs[16] = mk(0, 0, 32'h0,        0, 0, 4'h0, 32'h0,   32'h0,        0, 0, 0, 1, 1, 32'h1122beef);

    @(posedge clk); #1;
    for (int k = 0; k < NV; k++) begin
      step(vecs[k].rst, vecs[k].ireq, vecs[k].ia, vecs[k].dreq, vecs[k].dwr,
           vecs[k].st, vecs[k].da, vecs[k].dw);
      chk($sformatf("vec%0d_iaok", k), {31'b0, s_iaok}, {31'b0, vecs[k].e_iaok});
      chk($sformatf("vec%0d_daok", k), {31'b0, s_daok}, {31'b0, vecs[k].e_daok});
      chk($sformatf("vec%0d_idok", k), {31'b0, s_idok}, {31'b0, vecs[k].e_idok});
      chk($sformatf("vec%0d_ddok", k), {31'b0, s_ddok}, {31'b0, vecs[k].e_ddok});
      if (vecs[k].chk_rd)
        chk($sformatf("vec%0d_rdata", k), vecs[k].e_idok ? s_irdata : s_drdata,
            vecs[k].e_rdata);
    end

    // Both requesters held high: data wins 4 times, then fetch wins once, and so on.
    for (int k = 0; k < 15; k++) begin
      step(0, 1, 32'h600, 1, 0, 4'h0, 32'h500, 32'h0);
      chk($sformatf("starve%0d_iaok", k), {31'b0, s_iaok}, {31'b0, (k % 5) == 4});
      chk($sformatf("starve%0d_daok", k), {31'b0, s_daok}, {31'b0, (k % 5) != 4});
    end

    // Randomized traffic. A request that was not granted is held stable.
    p_i = 0; p_d = 0;
    for (int k = 0; k < 400; k++) begin
      if (!p_i) begin
        p_i  = $urandom_range(0, 2) != 0;
        p_ia = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
      end
      if (!p_d) begin
        p_d   = $urandom_range(0, 2) != 0;
        p_dwr = $urandom_range(0, 1) != 0;
        p_st  = 4'($urandom);
        p_da  = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
        p_dw  = $urandom;
      end
      step($urandom_range(0, 39) == 0, p_i, p_ia, p_d, p_dwr, p_st, p_da, p_dw);
      if (g_inst) p_i = 0;
      if (g_data) p_d = 0;
    end
    step(0, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
